fetch_stage: RTL and testbench

- Instruction-fetch stage and IF/ID pipeline register for the 5-stage ARM pipeline.
- Directly upstream of the decode-stage controller, which it feeds InstrD and PCPlus8D.
- Owns the PC, issues requests to instruction memory (one outstanding, variable latency) and buffers responses in a small prefetch FIFO.
- Applies redirects from the execute stage (taken branch) and the writeback stage (PC write), plus hazard-unit stall/flush.

---
 rtl/fetch_stage.sv | 173 +++++++++++++++++
 tb/tb_fetch_stage.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage: PC, single-outstanding imem fetch, prefetch FIFO, IF/ID register.
// Optional FETCH_PERF_EN macro adds perf_bubbles/perf_redirects counters.

module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     pop,
  output logic [WIDTH-1:0]         headData,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;

  assign headData = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= pushData;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + AW'(1);
      if (pop)  rdPtr <= rdPtr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // With a single outstanding request, a response can never land on a full queue.
  assert property (@(posedge clk) disable iff (reset)
    !(push && !clear && count == (AW+1)'(DEPTH)));
endmodule

module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter int          DEPTH    = 2,
  parameter logic [31:0] BUBBLE   = 32'hE1A00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        BranchTakenE,
  input  logic [31:0] ALUResultE,
  input  logic        PCSrcW,
  input  logic [31:0] ResultW,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus8D,
  output logic        ValidD,
  output logic        BufEmptyF
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_bubbles,
  output logic [31:0] perf_redirects
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   pcF;
  logic [31:0]   reqPc;
  logic [31:0]   target;
  logic          outstanding;
  logic          dropFlag;
  logic          redirect;
  logic          respond;
  logic          push;
  logic          pop;
  logic          bufEmpty;
  logic [CW-1:0] count;
  logic [63:0]   headData;

  assign redirect  = BranchTakenE | PCSrcW;
  assign target    = (BranchTakenE ? ALUResultE : ResultW) & 32'hFFFF_FFFC;
  assign imem_req  = !reset && !redirect && !StallF && !outstanding && (count < CW'(DEPTH));
  assign imem_addr = {pcF[31:2], 2'b00};

  // A response only counts when we are actually waiting for one; stragglers after reset are ignored.
  assign respond   = imem_rvalid && outstanding;
  assign push      = respond && !dropFlag && !redirect;
  assign bufEmpty  = (count == '0);
  assign BufEmptyF = bufEmpty;
  assign pop       = !FlushD && !StallD && !bufEmpty && !redirect;

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(64)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .clear    (redirect),
    .push     (push),
    .pushData ({reqPc, imem_rdata}),
    .pop      (pop),
    .headData (headData),
    .count    (count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pcF         <= RESET_PC;
      reqPc       <= '0;
      outstanding <= 1'b0;
      dropFlag    <= 1'b0;
    end else begin
      if (respond) begin
        outstanding <= 1'b0;
        dropFlag    <= 1'b0;
      end
      if (redirect) begin
        pcF <= target;
        // The in-flight request belongs to the abandoned path; swallow its response.
        if (outstanding && !imem_rvalid) dropFlag <= 1'b1;
      end else if (imem_req) begin
        outstanding <= 1'b1;
        reqPc       <= imem_addr;
        pcF         <= pcF + 32'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      InstrD   <= BUBBLE;
      PCPlus8D <= '0;
      ValidD   <= 1'b0;
    end else if (FlushD) begin
      InstrD <= BUBBLE;
      ValidD <= 1'b0;
    end else if (!StallD) begin
      if (pop) begin
        InstrD   <= headData[31:0];
        PCPlus8D <= headData[63:32] + 32'd8;
        ValidD   <= 1'b1;
      end else begin
        InstrD <= BUBBLE;
        ValidD <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic loadBubble;
  assign loadBubble = !FlushD && !StallD && !pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_bubbles   <= '0;
      perf_redirects <= '0;
    end else begin
      if (loadBubble) perf_bubbles   <= perf_bubbles + 32'd1;
      if (redirect)   perf_redirects <= perf_redirects + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage: vector table, directed corner cases, random run vs queue model.

module tb_fetch_stage;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] BUBBLE   = 32'hE1A00000;
  localparam logic [31:0] RESET_PC = 32'h00000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, StallF, StallD, FlushD, BranchTakenE, PCSrcW, imem_rvalid;
  logic [31:0] ALUResultE, ResultW, imem_rdata;
  logic        imem_req, ValidD, BufEmptyF;
  logic [31:0] imem_addr, InstrD, PCPlus8D;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_bubbles, perf_redirects;
`endif

  fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .StallF       (StallF),
    .StallD       (StallD),
    .FlushD       (FlushD),
    .BranchTakenE (BranchTakenE),
    .ALUResultE   (ALUResultE),
    .PCSrcW       (PCSrcW),
    .ResultW      (ResultW),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .InstrD       (InstrD),
    .PCPlus8D     (PCPlus8D),
    .ValidD       (ValidD),
    .BufEmptyF    (BufEmptyF)
`ifdef FETCH_PERF_EN
    ,
    .perf_bubbles   (perf_bubbles),
    .perf_redirects (perf_redirects)
`endif
  );

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] instrAt(input logic [31:0] addr);
    return 32'h5A000000 ^ addr;
  endfunction

  // Instruction memory: one request at a time, answers after memLat extra cycles.
  bit          autoMem;
  bit          memBusy;
  int          memLat;
  int          maxLat;
  logic [31:0] memAddr;

  // Reference model: fetch queue of {pc, instr} plus the D-stage slot.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;
  ent_t        q[$];
  logic [31:0] mPc, mReqPc, mInstr, mPc8;
  bit          mOut, mDrop, mValid, modelValid;

  function automatic bit predReq();
    return !reset && !(BranchTakenE || PCSrcW) && !StallF && !mOut && (q.size() < DEPTH);
  endfunction

  task automatic modelStep();
    bit          redir;
    bit          issue;
    logic [31:0] tgt;
    ent_t        e;
    if (reset) begin
      mPc = RESET_PC; mOut = 0; mDrop = 0; q.delete();
      mInstr = BUBBLE; mPc8 = 0; mValid = 0; modelValid = 1;
      return;
    end
    redir = BranchTakenE || PCSrcW;
    tgt   = (BranchTakenE ? ALUResultE : ResultW) & ~32'd3;
    issue = predReq();
    if (FlushD) begin
      mInstr = BUBBLE; mValid = 0;
    end else if (!StallD) begin
      if (q.size() != 0 && !redir) begin
        e = q.pop_front();
        mInstr = e.ins; mPc8 = e.pc + 32'd8; mValid = 1;
      end else begin
        mInstr = BUBBLE; mValid = 0;
      end
    end
    if (imem_rvalid && mOut) begin
      mOut = 0;
      if (mDrop || redir) mDrop = 0;
      else q.push_back({mReqPc, imem_rdata});
    end
    if (redir) begin
      if (mOut) mDrop = 1;
      mPc = tgt;
      q.delete();
    end
    if (issue) begin
      mOut = 1; mReqPc = mPc; mPc = mPc + 32'd4;
    end
  endtask

  task automatic half1();
    if (autoMem) begin
      imem_rvalid = memBusy && memLat == 0;
      imem_rdata  = imem_rvalid ? instrAt(memAddr) : 32'h0;
    end
    @(negedge clk);
    if (modelValid) begin
      chk("m_imem_req", {31'b0, imem_req}, {31'b0, predReq()});
      chk("m_imem_addr", imem_addr, mPc);
      chk("m_InstrD", InstrD, mInstr);
      chk("m_PCPlus8D", PCPlus8D, mPc8);
      chk("m_ValidD", {31'b0, ValidD}, {31'b0, mValid});
      chk("m_BufEmptyF", {31'b0, BufEmptyF}, {31'b0, q.size() == 0});
    end
  endtask

  task automatic half2();
    bit          reqSeen;
    logic [31:0] addrSeen;
    reqSeen  = imem_req;
    addrSeen = imem_addr;
    modelStep();
    @(posedge clk);
    #1;
    cyc++;
    if (autoMem) begin
      if (imem_rvalid) memBusy = 0;
      else if (memBusy && memLat != 0) memLat--;
      if (reqSeen) begin
        memBusy = 1; memAddr = addrSeen; memLat = $urandom_range(0, maxLat);
      end
    end
  endtask

  task automatic clearCtl();
    StallF = 0; StallD = 0; FlushD = 0; BranchTakenE = 0; PCSrcW = 0;
  endtask

  task automatic doReset();
    reset = 1; clearCtl(); imem_rvalid = 0; memBusy = 0;
    half1(); half2();
    reset = 0;
  endtask

  typedef struct {
    logic        rvalid;
    logic [31:0] rdata;
    logic        eReq;
    logic [31:0] eAddr;
    logic [31:0] eInstr;
    logic [31:0] ePc8;
    logic        eValid;
    logic        eEmpty;
  } vec_t;
  vec_t vt[9];

  initial begin
    reset = 1; clearCtl(); ALUResultE = 0; ResultW = 0; imem_rvalid = 0; imem_rdata = 0;
    autoMem = 0; maxLat = 0; memBusy = 0; memLat = 0; memAddr = 0; modelValid = 0;

    // Back-to-back fetch with a next-cycle memory, no stalls.
    vt[0] = '{1'b0, 32'h0,          1'b1, 32'd0,  BUBBLE,          32'd0,  1'b0, 1'b1};
    vt[1] = '{1'b1, instrAt(32'd0), 1'b0, 32'd4,  BUBBLE,          32'd0,  1'b0, 1'b1};
    vt[2] = '{1'b0, 32'h0,          1'b1, 32'd4,  BUBBLE,          32'd0,  1'b0, 1'b0};
    vt[3] = '{1'b1, instrAt(32'd4), 1'b0, 32'd8,  instrAt(32'd0),  32'd8,  1'b1, 1'b1};
    vt[4] = '{1'b0, 32'h0,          1'b1, 32'd8,  BUBBLE,          32'd8,  1'b0, 1'b0};
    vt[5] = '{1'b1, instrAt(32'd8), 1'b0, 32'd12, instrAt(32'd4),  32'd12, 1'b1, 1'b1};
    vt[6] = '{1'b0, 32'h0,          1'b1, 32'd12, BUBBLE,          32'd12, 1'b0, 1'b0};
    vt[7] = '{1'b1, instrAt(32'd12),1'b0, 32'd16, instrAt(32'd8),  32'd16, 1'b1, 1'b1};
    vt[8] = '{1'b0, 32'h0,          1'b1, 32'd16, BUBBLE,          32'd16, 1'b0, 1'b0};

    doReset();
    for (int i = 0; i < 9; i++) begin
      imem_rvalid = vt[i].rvalid;
      imem_rdata  = vt[i].rdata;
      half1();
      chk($sformatf("tbl%0d_req", i),   {31'b0, imem_req},  {31'b0, vt[i].eReq});
      chk($sformatf("tbl%0d_addr", i),  imem_addr,          vt[i].eAddr);
      chk($sformatf("tbl%0d_instr", i), InstrD,             vt[i].eInstr);
      chk($sformatf("tbl%0d_pc8", i),   PCPlus8D,           vt[i].ePc8);
      chk($sformatf("tbl%0d_valid", i), {31'b0, ValidD},    {31'b0, vt[i].eValid});
      chk($sformatf("tbl%0d_empty", i), {31'b0, BufEmptyF}, {31'b0, vt[i].eEmpty});
      half2();
    end

    // Reset with a request in flight; a late response afterwards must be ignored.
    reset = 1; imem_rvalid = 0;
    half1(); chk("rst_req_in_reset", {31'b0, imem_req}, 32'd0); half2();
    reset = 0; StallF = 1; imem_rvalid = 1; imem_rdata = 32'hBAD0BAD0;
    half1();
    chk("rst_instr", InstrD, BUBBLE);
    chk("rst_pc8", PCPlus8D, 32'd0);
    chk("rst_valid", {31'b0, ValidD}, 32'd0);
    chk("rst_empty", {31'b0, BufEmptyF}, 32'd1);
    chk("rst_addr", imem_addr, RESET_PC);
    half2();
    imem_rvalid = 0;
    half1(); chk("rst_late_empty", {31'b0, BufEmptyF}, 32'd1); half2();
    StallF = 0;

    // Taken branch while a request is outstanding; its response arrives two cycles later.
    doReset();
    half1(); chk("br_c0_req", {31'b0, imem_req}, 32'd1); half2();
    BranchTakenE = 1; ALUResultE = 32'h100; FlushD = 1;
    half1(); chk("br_c1_req", {31'b0, imem_req}, 32'd0); half2();
    BranchTakenE = 0; FlushD = 0;
    half1(); chk("br_c2_req", {31'b0, imem_req}, 32'd0); chk("br_c2_addr", imem_addr, 32'h100); half2();
    imem_rvalid = 1; imem_rdata = 32'hDEAD0000;
    half1(); half2();
    imem_rvalid = 0;
    half1();
    chk("br_drop_empty", {31'b0, BufEmptyF}, 32'd1);
    chk("br_c4_req", {31'b0, imem_req}, 32'd1);
    chk("br_c4_addr", imem_addr, 32'h100);
    half2();
    imem_rvalid = 1; imem_rdata = instrAt(32'h100);
    half1(); half2();
    imem_rvalid = 0;
    half1(); half2();
    half1();
    chk("br_instr", InstrD, instrAt(32'h100));
    chk("br_pc8", PCPlus8D, 32'h108);
    chk("br_valid", {31'b0, ValidD}, 32'd1);
    half2();

    // Execute redirect wins over writeback redirect.
    doReset();
    BranchTakenE = 1; PCSrcW = 1; ALUResultE = 32'h200; ResultW = 32'h300; FlushD = 1;
    half1(); chk("both_req", {31'b0, imem_req}, 32'd0); half2();
    clearCtl();
    half1(); chk("both_addr", imem_addr, 32'h200); chk("both_req1", {31'b0, imem_req}, 32'd1); half2();

    // StallD fills the queue and throttles fetch; FlushD+StallD leaves the queue alone.
    doReset();
    autoMem = 1; maxLat = 0;
    repeat (5) begin half1(); half2(); end
    StallD = 1;
    repeat (5) begin half1(); half2(); end
    half1();
    chk("stall_req", {31'b0, imem_req}, 32'd0);
    chk("stall_empty", {31'b0, BufEmptyF}, 32'd0);
    chk("stall_instr", InstrD, instrAt(32'd4));
    chk("stall_pc8", PCPlus8D, 32'd12);
    half2();
    FlushD = 1;
    half1(); half2();
    FlushD = 0; StallD = 0;
    half1();
    chk("fs_instr", InstrD, BUBBLE);
    chk("fs_valid", {31'b0, ValidD}, 32'd0);
    chk("fs_req", {31'b0, imem_req}, 32'd0);
    chk("fs_empty", {31'b0, BufEmptyF}, 32'd0);
    half2();
    repeat (12) begin half1(); half2(); end

    // Random traffic against the model.
    maxLat = 3;
    for (int i = 0; i < 3000; i++) begin
      StallF = ($urandom_range(0, 4) == 0);
      StallD = ($urandom_range(0, 4) == 0);
      FlushD = ($urandom_range(0, 9) == 0);
      BranchTakenE = 0; PCSrcW = 0;
      if ($urandom_range(0, 11) == 0) begin
        BranchTakenE = 1'($urandom_range(0, 1));
        PCSrcW       = !BranchTakenE || ($urandom_range(0, 1) == 1);
        FlushD       = 1;
        ALUResultE   = $urandom;
        ResultW      = $urandom;
        if ($urandom_range(0, 3) == 0) ALUResultE = 32'hFFFFFFF4;
      end
      reset = ($urandom_range(0, 199) == 0);
      half1(); half2();
    end
    reset = 0; clearCtl();
    repeat (10) begin half1(); half2(); end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
